pattern_count_engine: RTL and testbench
=======================================

// Module: pattern_count_engine
// PURPOSE
//  Streaming accelerator for the program-3 pattern search; replaces the software loop.
//  Accepts N_BYTES bytes of a message, MSB-first. Counts occurrences of a PAT_W-bit pattern in three ways:
//  - in-byte: CtB
//  - bytes holding >=1 in-byte match: CtO
//  - across byte boundaries: CtS
//  Sits beside top_level data memory; a sequencer feeds it bytes and writes the counts back.
// PARAMETERS
//  PAT_W    5   pattern width in bits; 1 <= PAT_W <= BYTE_W
//  BYTE_W   8   width of one message element
//  N_BYTES  32  elements per message; >= 1
//  CNT_W    8   width of each result counter; counters saturate at 2**CNT_W-1
// PORTS
//  Clk      in   1       clock; all state updates on rising edge
//  Reset    in   1       synchronous, active-high; forces IDLE, clears all state
//  Start    in   1       begin a new message; sampled in IDLE or DONE only
//  Pattern  in   PAT_W   search pattern; latched on accepted Start
//  InData   in   BYTE_W  next message byte, bit BYTE_W-1 is first in stream order
//  InValid  in   1       InData valid
//  InReady  out  1       byte accepted when InValid & InReady
//  Busy     out  1       high in RUN
//  Done     out  1       high in DONE; counts stable while high
//  CtB      out  CNT_W   in-byte match count
//  CtO      out  CNT_W   count of bytes with >=1 in-byte match
//  CtS      out  CNT_W   match count over the full concatenated bit stream
// BEHAVIOUR
//  Reset values: InReady=0, Busy=0, Done=0, CtB=CtO=CtS=0, byte index=0, tail=0, state=IDLE.
//  FSM states and transitions:
//  - IDLE: Start -> RUN. Latch Pattern, clear counters/index/tail.
//  - RUN: InReady=1. Each accepted byte increments the index; accepting byte N_BYTES-1 -> DONE next cycle.
//  - DONE: Done=1, counts held. Start -> RUN (same clearing as IDLE); otherwise stay.
//  Start in RUN is ignored. InValid low stalls with no state change. InData is don't-care when not accepted.
//  Per accepted byte b:
//  - m = number of k in 0..BYTE_W-PAT_W with b[k+PAT_W-1:k]==pat.
//  - CtB += m; CtO += (m!=0).
//  Cross-byte window:
//  - w = {tail, b}, tail = last PAT_W-1 stream bits.
//  - First byte (index 0): CtS += m.
//  - Later bytes: CtS += number of the BYTE_W windows of w, starting at each bit of b's contribution, that equal pat.
//  - tail <= low PAT_W-1 bits of w after the update. PAT_W==1 means no tail.
//  - Totals: N_BYTES*BYTE_W-PAT_W+1 windows for CtS, N_BYTES*(BYTE_W-PAT_W+1) for CtB.
//  Timing and arithmetic:
//  - Counter updates are registered: visible the cycle after acceptance.
//  - Done rises the cycle after the last accept, with final counts. Throughput is 1 byte/cycle.
//  - Additions saturate at 2**CNT_W-1; no wrap.
//  - Internal per-byte sums use $clog2(BYTE_W+1) bits.
//  Reset in any state (including mid-RUN) wins over Start/InValid the same cycle; partial counts are discarded.
// CONFIGURATION
//  PCE_PAT_MASK_EN defined:
//  - Adds input PatMask [PAT_W-1:0], latched with Pattern on Start.
//  - A window matches when ((window ^ pat) & mask)==0; mask bit 0 = don't-care.
//  Undefined: no PatMask port; exact match (mask all ones).
// STRUCTURE
//  pce_pkg: state enum {IDLE,RUN,DONE}; saturating-add function; the PAT_W<=BYTE_W parameter check.
//  Sub-module pattern_window_cmp:
//  - Combinational; params PAT_W and SRC_W.
//  - Returns the count of matching PAT_W windows in an SRC_W-bit vector.
//  - Instanced twice: in-byte (SRC_W=BYTE_W) and cross (SRC_W=BYTE_W+PAT_W-1).
// TESTING (defaults unless stated)
//  1. pat=5'b10101, all bytes 8'h55, InValid const 1 -> CtB=64, CtO=32, CtS=126; Done 33 cycles after Start.
//  2. pat=5'b00000, all bytes 8'h00 -> CtB=128, CtO=32, CtS=252.
//  3. pat=5'b11111, bytes alternate 8'h0F,8'hF0 -> CtB=0, CtO=0, CtS=64.
//  4. Test 1 with InValid toggling every cycle -> identical counts; Done only after 32nd accept.
//  5. Reset after 10 bytes, then Start with test-2 data -> 128/32/252; no residue from the aborted run.
//  6. CNT_W=6, test-2 data -> CtB=63, CtO=32, CtS=63 (saturated).
//  7. (PCE_PAT_MASK_EN) PatMask=0, random data -> CtB=128, CtO=32, CtS=252.
//  Scoreboard: reuse the byte/stream reference loops of the program-3 bench, random pattern and data, 1000 seeds.

Source files
------------

// File: rtl/pce_pkg.sv
// Shared types and helpers for the pattern count engine: FSM state encoding,
// saturating accumulate, and the legal PAT_W/BYTE_W relationship.
package pce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Adds in 33 bits so the carry out of a full-width add is never lost.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

    function automatic bit pat_w_valid(input int pat_w, input int byte_w);
        return (pat_w >= 1) && (pat_w <= byte_w);
    endfunction

endpackage

// File: rtl/pattern_window_cmp.sv
// Combinational window matcher: counts the PAT_W-bit windows of src that match
// pat on every bit where mask is 1.
module pattern_window_cmp #(
    parameter int PAT_W = 5,
    parameter int SRC_W = 8,
    parameter int SUM_W = $clog2(SRC_W - PAT_W + 2)
) (
    input  logic [SRC_W-1:0] src,
    input  logic [PAT_W-1:0] pat,
    input  logic [PAT_W-1:0] mask,
    output logic [SUM_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int k = 0; k <= SRC_W - PAT_W; k++) begin
            if (((src[k +: PAT_W] ^ pat) & mask) == '0) begin
                count = count + SUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/pattern_count_engine.sv
// Streaming pattern counter: in-byte matches, matching bytes and whole-stream matches.
// Define PCE_PAT_MASK_EN to add the PatMask don't-care input.
module pattern_count_engine
    import pce_pkg::*;
#(
    parameter int PAT_W   = 5,
    parameter int BYTE_W  = 8,
    parameter int N_BYTES = 32,
    parameter int CNT_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PAT_W-1:0]  Pattern,
`ifdef PCE_PAT_MASK_EN
    input  logic [PAT_W-1:0]  PatMask,
`endif
    input  logic [BYTE_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  CtB,
    output logic [CNT_W-1:0]  CtO,
    output logic [CNT_W-1:0]  CtS
);

    localparam int SUM_W  = $clog2(BYTE_W + 1);
    localparam int IDX_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int TAIL_W = (PAT_W > 1) ? PAT_W - 1 : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    if (!pat_w_valid(PAT_W, BYTE_W)) begin : g_bad_pat_w
        $error("pattern_count_engine: PAT_W must satisfy 1 <= PAT_W <= BYTE_W");
    end
    if (N_BYTES < 1) begin : g_bad_n_bytes
        $error("pattern_count_engine: N_BYTES must be at least 1");
    end

    state_t             state;
    state_t             state_next;
    logic [PAT_W-1:0]   pat;
    logic [PAT_W-1:0]   mask;
    logic [PAT_W-1:0]   mask_in;
    logic [IDX_W-1:0]   idx;
    logic [TAIL_W-1:0]  tail;
    logic [TAIL_W-1:0]  tail_next;
    logic [CNT_W-1:0]   ctb;
    logic [CNT_W-1:0]   cto;
    logic [CNT_W-1:0]   cts;
    logic [SUM_W-1:0]   byte_cnt;
    logic [SUM_W-1:0]   cross_cnt;
    logic [SUM_W-1:0]   stream_cnt;
    logic               start_ok;
    logic               accept;

`ifdef PCE_PAT_MASK_EN
    assign mask_in = PatMask;
`else
    assign mask_in = '1;
`endif

    assign start_ok = Start && ((state == IDLE) || (state == DONE));
    assign accept   = InValid && (state == RUN);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                InReady = 1'b1;
                Busy    = 1'b1;
                if (InValid && (idx == LAST_IDX)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    pattern_window_cmp #(
        .PAT_W (PAT_W),
        .SRC_W (BYTE_W),
        .SUM_W (SUM_W)
    ) u_byte_cmp (
        .src   (InData),
        .pat   (pat),
        .mask  (mask),
        .count (byte_cnt)
    );

    // The cross matcher sees the previous byte's last PAT_W-1 bits ahead of the
    // new byte, so each new bit position starts exactly one window.
    if (PAT_W > 1) begin : g_cross
        logic [BYTE_W+PAT_W-2:0] window;

        assign window    = {tail, InData};
        assign tail_next = window[TAIL_W-1:0];

        pattern_window_cmp #(
            .PAT_W (PAT_W),
            .SRC_W (BYTE_W + PAT_W - 1),
            .SUM_W (SUM_W)
        ) u_cross_cmp (
            .src   (window),
            .pat   (pat),
            .mask  (mask),
            .count (cross_cnt)
        );
    end else begin : g_no_cross
        assign cross_cnt = byte_cnt;
        assign tail_next = '0;
    end

    // The first byte has no predecessor, so only its own windows count.
    assign stream_cnt = (idx == '0) ? byte_cnt : cross_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pat  <= '0;
            mask <= '0;
            idx  <= '0;
            tail <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
        end else if (start_ok) begin
            pat  <= Pattern;
            mask <= mask_in;
            idx  <= '0;
            tail <= '0;
            ctb  <= '0;
            cto  <= '0;
            cts  <= '0;
        end else if (accept) begin
            idx  <= idx + IDX_W'(1);
            tail <= tail_next;
            ctb  <= CNT_W'(sat_add(32'(ctb), 32'(byte_cnt), CNT_MAX));
            cto  <= CNT_W'(sat_add(32'(cto), 32'(byte_cnt != '0), CNT_MAX));
            cts  <= CNT_W'(sat_add(32'(cts), 32'(stream_cnt), CNT_MAX));
        end
    end

    assign CtB = ctb;
    assign CtO = cto;
    assign CtS = cts;

endmodule

// File: tb/tb_pattern_count_engine.sv
// Bench for pattern_count_engine: directed cases plus randomized messages checked
// against a bit-stream window model; a CNT_W=6 instance covers saturation.
module tb_pattern_count_engine;

    localparam int P = 5;
    localparam int B = 8;
    localparam int N = 32;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic [P-1:0] Pattern;
    logic [P-1:0] PatMask;
    logic [B-1:0] InData;
    logic         InValid;
    logic         InReady, Busy, Done;
    logic [7:0]   CtB, CtO, CtS;
    logic         InReady6, Busy6, Done6;
    logic [5:0]   CtB6, CtO6, CtS6;

    int checks = 0;
    int errors = 0;
    logic [B-1:0] msg [N];
    int exp_b, exp_o, exp_s;

    always #5 Clk = ~Clk;

    pattern_count_engine #(.PAT_W(P), .BYTE_W(B), .N_BYTES(N), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Pattern(Pattern),
`ifdef PCE_PAT_MASK_EN
        .PatMask(PatMask),
`endif
        .InData(InData), .InValid(InValid), .InReady(InReady), .Busy(Busy),
        .Done(Done), .CtB(CtB), .CtO(CtO), .CtS(CtS)
    );

    pattern_count_engine #(.PAT_W(P), .BYTE_W(B), .N_BYTES(N), .CNT_W(6)) dut6 (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Pattern(Pattern),
`ifdef PCE_PAT_MASK_EN
        .PatMask(PatMask),
`endif
        .InData(InData), .InValid(InValid), .InReady(InReady6), .Busy(Busy6),
        .Done(Done6), .CtB(CtB6), .CtO(CtO6), .CtS(CtS6)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, expv);
        end
    endtask

    // Flatten the message MSB-first and slide a PAT_W window over every bit offset.
    task automatic model(input logic [P-1:0] p, input logic [P-1:0] mk);
        logic bits [N*B];
        logic [P-1:0] w;
        bit hit [N];
        exp_b = 0; exp_o = 0; exp_s = 0;
        for (int i = 0; i < N; i++) begin
            hit[i] = 1'b0;
            for (int j = 0; j < B; j++) bits[i*B + j] = msg[i][B-1-j];
        end
        for (int t = 0; t <= N*B - P; t++) begin
            for (int q = 0; q < P; q++) w[P-1-q] = bits[t+q];
            if (((w ^ p) & mk) == '0) begin
                exp_s++;
                if ((t % B) + P <= B) begin
                    exp_b++;
                    hit[t / B] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) if (hit[i]) exp_o++;
    endtask

    function automatic int sat(input int v, input int max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // mode 0: InValid constant 1; mode 1: toggling; mode 2: random with Start/Pattern noise.
    task automatic run_msg(input logic [P-1:0] p, input int mode, output int edges);
        int i;
        logic vt;
        logic v;
        @(negedge Clk);
        Start = 1'b1; Pattern = p; InValid = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        edges = 1;
        i = 0;
        vt = 1'b0;
        while (i < N && edges < 1000) begin
            if (mode == 0) v = 1'b1;
            else if (mode == 1) begin v = vt; vt = ~vt; end
            else v = 1'($urandom_range(0, 1));
            if (mode != 0) begin
                Start   = 1'($urandom_range(0, 1));
                Pattern = P'($urandom);
            end
            InValid = v;
            InData  = v ? msg[i] : B'($urandom);
            check("busy_in_run", 32'(Busy), 32'd1);
            check("done_before_last", 32'(Done), 32'd0);
            @(negedge Clk);
            edges++;
            if (v) i++;
        end
        Start = 1'b0; InValid = 1'b0;
        check("accept_budget", 32'(i), 32'(N));
        check("done_after_last", 32'(Done), 32'd1);
        check("busy_after_last", 32'(Busy), 32'd0);
    endtask

    task automatic check_model(input string tag, input logic [P-1:0] p, input logic [P-1:0] mk);
        model(p, mk);
        check({tag, "_ctb"}, 32'(CtB), 32'(sat(exp_b, 255)));
        check({tag, "_cto"}, 32'(CtO), 32'(sat(exp_o, 255)));
        check({tag, "_cts"}, 32'(CtS), 32'(sat(exp_s, 255)));
        check({tag, "_ctb6"}, 32'(CtB6), 32'(sat(exp_b, 63)));
        check({tag, "_cto6"}, 32'(CtO6), 32'(sat(exp_o, 63)));
        check({tag, "_cts6"}, 32'(CtS6), 32'(sat(exp_s, 63)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        logic [P-1:0] rp;
        logic [P-1:0] rm;
        Reset = 1'b1; Start = 1'b1; Pattern = '0; PatMask = '1; InData = '0; InValid = 1'b1;
        repeat (3) @(negedge Clk);
        check("rst_inready", 32'(InReady), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_ctb", 32'(CtB), 32'd0);
        check("rst_cto", 32'(CtO), 32'd0);
        check("rst_cts", 32'(CtS), 32'd0);
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0;

        // Test 1
        for (int i = 0; i < N; i++) msg[i] = 8'h55;
        run_msg(5'b10101, 0, edges);
        check("t1_latency", 32'(edges), 32'd33);
        check("t1_ctb", 32'(CtB), 32'd64);
        check("t1_cto", 32'(CtO), 32'd32);
        check("t1_cts", 32'(CtS), 32'd126);
        check_model("t1", 5'b10101, '1);
        repeat (3) @(negedge Clk);
        check("t1_hold_done", 32'(Done), 32'd1);
        check("t1_hold_cts", 32'(CtS), 32'd126);

        // Test 2 and saturation on the CNT_W=6 instance
        for (int i = 0; i < N; i++) msg[i] = 8'h00;
        run_msg(5'b00000, 0, edges);
        check("t2_ctb", 32'(CtB), 32'd128);
        check("t2_cto", 32'(CtO), 32'd32);
        check("t2_cts", 32'(CtS), 32'd252);
        check("t6_ctb", 32'(CtB6), 32'd63);
        check("t6_cto", 32'(CtO6), 32'd32);
        check("t6_cts", 32'(CtS6), 32'd63);

        // Test 3
        for (int i = 0; i < N; i++) msg[i] = (i % 2 == 0) ? 8'h0F : 8'hF0;
        run_msg(5'b11111, 0, edges);
        check("t3_ctb", 32'(CtB), 32'd0);
        check("t3_cto", 32'(CtO), 32'd0);
        check("t3_cts", 32'(CtS), 32'd64);

        // Test 4
        for (int i = 0; i < N; i++) msg[i] = 8'h55;
        run_msg(5'b10101, 1, edges);
        check("t4_ctb", 32'(CtB), 32'd64);
        check("t4_cto", 32'(CtO), 32'd32);
        check("t4_cts", 32'(CtS), 32'd126);

        // Test 5: abort mid-run; Reset beats Start in the same cycle
        for (int i = 0; i < N; i++) msg[i] = 8'hFF;
        @(negedge Clk);
        Start = 1'b1; Pattern = 5'b11111;
        @(negedge Clk);
        Start = 1'b0; InValid = 1'b1;
        for (int i = 0; i < 10; i++) begin InData = msg[i]; @(negedge Clk); end
        check("t5_partial_nonzero", 32'(CtB != 0), 32'd1);
        Reset = 1'b1; Start = 1'b1;
        @(negedge Clk);
        check("t5_rst_busy", 32'(Busy), 32'd0);
        check("t5_rst_ctb", 32'(CtB), 32'd0);
        check("t5_rst_cts", 32'(CtS), 32'd0);
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0;
        @(negedge Clk);
        check("t5_idle_busy", 32'(Busy), 32'd0);
        for (int i = 0; i < N; i++) msg[i] = 8'h00;
        run_msg(5'b00000, 0, edges);
        check("t5_ctb", 32'(CtB), 32'd128);
        check("t5_cto", 32'(CtO), 32'd32);
        check("t5_cts", 32'(CtS), 32'd252);

`ifdef PCE_PAT_MASK_EN
        // Test 7
        for (int i = 0; i < N; i++) msg[i] = B'($urandom);
        PatMask = '0;
        run_msg(P'($urandom), 0, edges);
        check("t7_ctb", 32'(CtB), 32'd128);
        check("t7_cto", 32'(CtO), 32'd32);
        check("t7_cts", 32'(CtS), 32'd252);
`endif

        // Randomized scoreboard; a small alphabet keeps match counts interesting
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                msg[i] = (r % 3 == 0) ? B'($urandom) : {4{2'($urandom_range(0, 3))}};
            end
            rp = P'($urandom);
            rm = '1;
`ifdef PCE_PAT_MASK_EN
            rm = P'($urandom);
            PatMask = rm;
`endif
            run_msg(rp, r % 3, edges);
`ifdef PCE_PAT_MASK_EN
            PatMask = P'($urandom);
`endif
            check_model("rand", rp, rm);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
